// File: rtl/iob_cache_victim_select_pkg.sv
// Shared definitions for the cache victim-select engine: the replacement
// policy codes and the LFSR step used by the RANDOM policy.
package iob_cache_victim_select_pkg;

    // Replacement policy codes
    localparam int IOB_CACHE_MEMORY_PLRU_MRU  = 0;
    localparam int IOB_CACHE_MEMORY_PLRU_TREE = 1;
    localparam int IOB_CACHE_MEMORY_RANDOM    = 2;

    // 16-bit Fibonacci LFSR, taps 16,14,13,11 (bit 15 is tap 16)
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction

endpackage

// File: rtl/iob_cache_onehot_to_bin.sv
// One-hot to binary encoder. An all-zero input yields zero.
module iob_cache_onehot_to_bin #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] onehot_i,
    output logic [W-1:0] bin_o
);

    // OR together the indices of every set bit
    always_comb begin
        bin_o = '0;
        for (int i = 0; i < N; i++)
            if (onehot_i[i]) bin_o = bin_o | W'(i);
    end

endmodule

// File: rtl/iob_cache_plru_tree.sv
// Combinational pseudo-LRU binary tree. Node n sits at bit n-1; its children
// are 2n and 2n+1, and leaf id minus N_WAYS is the way index. A node value of
// 0 points left, 1 points right.
module iob_cache_plru_tree #(
    parameter int N_WAYS  = 4,
    parameter int NWAYS_W = $clog2(N_WAYS)
) (
    input  logic [N_WAYS-2:0]  tree_i,
    output logic [NWAYS_W-1:0] victim_o,
    input  logic [N_WAYS-2:0]  upd_tree_i,
    input  logic [N_WAYS-1:0]  hit_i,
    output logic [N_WAYS-2:0]  next_o
);

    // Follow the node pointers from the root down to a leaf
    always_comb begin
        int n;
        n = 1;
        for (int l = 0; l < NWAYS_W; l++)
            n = 2 * n + int'(tree_i[n-1]);
        victim_o = NWAYS_W'(n - N_WAYS);
    end

    // A hit below a node turns that node away from the hit subtree;
    // nodes with no hit beneath them keep their value
    always_comb begin
        logic hit_l;
        logic hit_r;
        hit_l  = 1'b0;
        hit_r  = 1'b0;
        next_o = upd_tree_i;
        for (int n = 1; n < N_WAYS; n++) begin
            hit_l = 1'b0;
            hit_r = 1'b0;
            for (int i = 0; i < N_WAYS; i++) begin
                for (int s = 0; s < NWAYS_W; s++) begin
                    if (((N_WAYS + i) >> s) == 2 * n)     hit_l = hit_l | hit_i[i];
                    if (((N_WAYS + i) >> s) == 2 * n + 1) hit_r = hit_r | hit_i[i];
                end
            end
            next_o[n-1] = hit_l | (upd_tree_i[n-1] & ~hit_r);
        end
    end

endmodule

// File: rtl/iob_cache_victim_select.sv
// Per-set replacement engine. Holds replacement state for every set, answers
// victim requests one cycle later, prefers invalid ways, never evicts locked
// ways, and can clear all set state with a one-set-per-cycle flush sweep.
module iob_cache_victim_select
    import iob_cache_victim_select_pkg::*;
#(
    parameter int          N_WAYS      = 4,
    parameter int          SET_INDEX_W = 2,
    parameter int          NWAYS_W     = $clog2(N_WAYS),
    parameter int          REP_POLICY  = IOB_CACHE_MEMORY_PLRU_TREE,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                   clk_i,
    input  logic                   arst_n_i,
    input  logic                   cke_i,
    input  logic                   flush_i,
    output logic                   busy_o,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic [SET_INDEX_W-1:0] req_set_i,
    input  logic [N_WAYS-1:0]      way_valid_i,
    input  logic [N_WAYS-1:0]      lock_i,
    output logic                   resp_valid_o,
    output logic [N_WAYS-1:0]      resp_way_o,
    output logic [NWAYS_W-1:0]     resp_way_bin_o,
    output logic                   resp_none_o,
    input  logic                   upd_valid_i,
    input  logic [SET_INDEX_W-1:0] upd_set_i,
    input  logic [N_WAYS-1:0]      upd_way_i
);

    localparam int N_SETS = 2 ** SET_INDEX_W;
    localparam logic [N_WAYS-1:0] ONE = N_WAYS'(1);

    typedef enum logic {IDLE, FLUSH} fsm_t;

    fsm_t                          fsm;
    logic [SET_INDEX_W-1:0]        flush_set;
    // Sized for the widest policy (MRU); the tree uses the low N_WAYS-1
    // bits and leaves the top bit at zero
    logic [N_SETS-1:0][N_WAYS-1:0] set_state;
    logic [15:0]                   lfsr;

    logic                          req_fire;
    logic [N_WAYS-1:0]             rd_state;
    logic [N_WAYS-1:0]             upd_old;
    logic [N_WAYS-1:0]             upd_next;
    logic [N_WAYS-1:0]             mru_or;
    logic [N_WAYS-1:0]             mru_next;
    logic [NWAYS_W-1:0]            mru_victim;
    logic [NWAYS_W-1:0]            tree_victim;
    logic [N_WAYS-2:0]             tree_next;
    logic [NWAYS_W-1:0]            pol_victim;
    logic [N_WAYS-1:0]             pol_oh;
    logic [N_WAYS-1:0]             inv_unl;
    logic [N_WAYS-1:0]             unl;
    logic [N_WAYS-1:0]             sel_oh;
    logic                          sel_none;
    logic [NWAYS_W-1:0]            sel_bin;

    assign req_ready_o = (fsm == IDLE);
    assign req_fire    = req_valid_i & req_ready_o;
    // Responses read the pre-update state; updates are never bypassed
    assign rd_state    = set_state[req_set_i];
    assign upd_old     = set_state[upd_set_i];

    iob_cache_plru_tree #(
        .N_WAYS (N_WAYS),
        .NWAYS_W(NWAYS_W)
    ) u_tree (
        .tree_i    (rd_state[N_WAYS-2:0]),
        .victim_o  (tree_victim),
        .upd_tree_i(upd_old[N_WAYS-2:0]),
        .hit_i     (upd_way_i),
        .next_o    (tree_next)
    );

    // MRU: victim is the lowest clear bit; saturating to all ones restarts
    always_comb begin
        mru_victim = '0;
        for (int i = N_WAYS - 1; i >= 0; i--)
            if (!rd_state[i]) mru_victim = NWAYS_W'(i);
        mru_or   = upd_old | upd_way_i;
        mru_next = (&mru_or) ? upd_way_i : mru_or;
    end

    // Pick the policy victim and next-state according to REP_POLICY
    always_comb begin
        pol_victim = tree_victim;
        upd_next   = {1'b0, tree_next};
        if (REP_POLICY == IOB_CACHE_MEMORY_PLRU_MRU) begin
            pol_victim = mru_victim;
            upd_next   = mru_next;
        end else if (REP_POLICY == IOB_CACHE_MEMORY_RANDOM) begin
            pol_victim = lfsr[NWAYS_W-1:0];
            upd_next   = upd_old;
        end
    end

    // Invalid-unlocked first, then the policy choice, then any unlocked way
    always_comb begin
        inv_unl  = ~way_valid_i & ~lock_i;
        unl      = ~lock_i;
        pol_oh   = ONE << pol_victim;
        sel_none = 1'b0;
        if (|inv_unl)
            sel_oh = inv_unl & (~inv_unl + ONE);
        else if (!lock_i[pol_victim])
            sel_oh = pol_oh;
        else if (|unl)
            sel_oh = unl & (~unl + ONE);
        else begin
            sel_oh   = '0;
            sel_none = 1'b1;
        end
    end

    iob_cache_onehot_to_bin #(
        .N(N_WAYS),
        .W(NWAYS_W)
    ) u_bin (
        .onehot_i(sel_oh),
        .bin_o   (sel_bin)
    );

    // Control FSM: applies updates in IDLE, sweeps one set per cycle in FLUSH
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            fsm       <= IDLE;
            busy_o    <= 1'b0;
            flush_set <= '0;
            set_state <= '0;
        end else if (cke_i) begin
            case (fsm)
                IDLE: begin
                    if (upd_valid_i && (|upd_way_i) &&
                        (REP_POLICY != IOB_CACHE_MEMORY_RANDOM))
                        set_state[upd_set_i] <= upd_next;
                    if (flush_i) begin
                        fsm       <= FLUSH;
                        busy_o    <= 1'b1;
                        flush_set <= '0;
                    end
                end
                FLUSH: begin
                    set_state[flush_set] <= '0;
                    flush_set            <= flush_set + SET_INDEX_W'(1);
                    if (flush_set == SET_INDEX_W'(N_SETS - 1)) begin
                        fsm    <= IDLE;
                        busy_o <= 1'b0;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

    // Registered one-cycle response
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            resp_valid_o   <= 1'b0;
            resp_way_o     <= '0;
            resp_way_bin_o <= '0;
            resp_none_o    <= 1'b0;
        end else if (cke_i) begin
            resp_valid_o <= req_fire;
            if (req_fire) begin
                resp_way_o     <= sel_oh;
                resp_way_bin_o <= sel_bin;
                resp_none_o    <= sel_none;
            end
        end
    end

    // LFSR steps once per accepted request under the RANDOM policy
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i)
            lfsr <= LFSR_SEED;
        else if (cke_i && req_fire && (REP_POLICY == IOB_CACHE_MEMORY_RANDOM))
            lfsr <= lfsr_next(lfsr);
    end

endmodule

// File: doc/iob_cache_victim_select.md
Name: iob_cache_victim_select

Overview:
Per-set replacement engine for the next-generation cache memory, successor to the combinational replacement policy. It owns the per-set replacement state and answers victim requests with one cycle of latency. Victim selection is validity-aware (invalid ways are filled first) and lock-aware (locked ways are never evicted). A flush FSM clears the replacement state of every set. It sits between the tag/valid arrays and the cache control FSM.

Parameters:
N_WAYS, 4, number of ways; power of 2, >=2
SET_INDEX_W, 2, set index width; N_SETS = 2**SET_INDEX_W
NWAYS_W, $clog2(N_WAYS), way index width
REP_POLICY, `IOB_CACHE_MEMORY_PLRU_TREE, selects PLRU_MRU, PLRU_TREE or RANDOM
LFSR_SEED, 16'hACE1, reset value of the RANDOM LFSR; must be nonzero

Ports:
clk_i  in  1  clock
arst_n_i  in  1  asynchronous reset, active-low
cke_i  in  1  clock enable; when low, all state is frozen
flush_i  in  1  pulse that starts a state clear of all sets
busy_o  out  1  flush sweep in progress
req_valid_i  in  1  victim request
req_ready_o  out  1  request accepted when req_valid_i && req_ready_o
req_set_i  in  SET_INDEX_W  set of the request
way_valid_i  in  N_WAYS  valid bits of the requested set, sampled with the request
lock_i  in  N_WAYS  ways that must not be evicted, sampled with the request
resp_valid_o  out  1  one-cycle response strobe
resp_way_o  out  N_WAYS  victim way, one-hot
resp_way_bin_o  out  NWAYS_W  victim way, binary
resp_none_o  out  1  all ways locked; no victim available
upd_valid_i  in  1  access update (hit or fill)
upd_set_i  in  SET_INDEX_W  set of the update
upd_way_i  in  N_WAYS  accessed way, one-hot

Behaviour:
- Reset (arst_n_i=0), asynchronous:
  - all set state = 0; LFSR = LFSR_SEED; FSM = IDLE
  - busy_o=0, resp_valid_o=0, resp_way_o=0, resp_way_bin_o=0, resp_none_o=0
- State width per set:
  - PLRU_TREE: N_WAYS-1 bits. Node 1 is the root; node n has children 2n and 2n+1. 0 traverses left, 1 traverses right. Leaf id minus N_WAYS gives the way index.
  - PLRU_MRU: N_WAYS bits
  - RANDOM: no per-set state; a 16-bit Fibonacci LFSR with taps 16,14,13,11
- Update, on upd_valid_i with FSM in IDLE, takes effect the next cycle:
  - TREE: each node becomes (hit in left subtree) | (old value & no hit in right subtree)
  - MRU: new = old|hit; if that is all ones, new = hit
  - upd_way_i==0 leaves the state unchanged
- Request: req_ready_o = (FSM==IDLE). On an accepted request, the state of req_set_i is read combinationally and the response is registered; resp_valid_o is high for exactly 1 cycle, in the next cycle. Back-to-back requests are allowed, giving one response per cycle.
- Policy victim P:
  - TREE: tree traversal
  - MRU: lowest-index bit that is 0
  - RANDOM: LFSR[NWAYS_W-1:0]; the LFSR advances once per accepted request
- Victim priority:
  1. Lowest-index way that is invalid and unlocked.
  2. Otherwise P, if P is unlocked.
  3. Otherwise the lowest-index unlocked way.
  4. If all ways are locked: resp_none_o=1, resp_way_o=0, resp_way_bin_o=0.
- An update and a request in the same cycle to the same set: the response uses the pre-update state. The update is not bypassed.
- FSM IDLE->FLUSH on flush_i:
  - FLUSH writes 0 to set k in cycle k, for k=0..N_SETS-1, then returns to IDLE
  - busy_o=1 for exactly N_SETS cycles
  - flush_i during FLUSH is ignored; it does not restart the sweep
  - updates during FLUSH are dropped; requests stall
  - a response already registered is still delivered
- Reset asserted mid-flush aborts the sweep and applies the reset values immediately.
- The way count and set count are generic; no other encodings are supported.

Decomposition:
- Policy codes go in iob_cache_memory_conf.vh: PLRU_MRU, PLRU_TREE, and the new RANDOM.
- FSM state localparams (IDLE, FLUSH) stay local to the module.
- Sub-module iob_cache_plru_tree is combinational and provides:
  - tree state -> victim
  - tree state + hit -> next state
- The one-hot to binary conversion reuses iob_cache_onehot_to_bin.

Test Plan:
All scenarios use N_WAYS=4, SET_INDEX_W=2 and REP_POLICY=PLRU_TREE unless stated otherwise.
1. Reset; request set 0 with valid=4'b1111, lock=0 -> next cycle resp_valid_o=1 and resp_way_bin_o=0. Then update set 0 with way 4'b0001 (state becomes 3'b011); request again -> resp_way_bin_o=2.
2. Request with valid=4'b1011 -> resp_way_o=4'b0100, whatever the tree state is.
3. From the state in scenario 1 (P=2): request with lock=4'b0100 -> resp_way_bin_o=0. Request with lock=4'b1111 -> resp_none_o=1 and resp_way_o=0.
4. After updates to all 4 sets, pulse flush_i:
   - busy_o=1 and req_ready_o=0 for exactly 4 cycles
   - an update issued during the flush is dropped
   - afterwards every set returns way 0
5. In the same cycle, update set 1 with way 4'b0001 and request set 1 -> response way 0 (old state). The following request -> way 2.
6. REP_POLICY=RANDOM with seed 16'hACE1: 8 consecutive requests return the LFSR low bits in sequence. Assert arst_n_i mid-flush -> busy_o=0 immediately and the LFSR is back to the seed.
